alu_share_arbiter: RTL and testbench

- Shares one WIDTH-bit ALU (ADD/SUB/AND/XOR) among NREQ requesters.
- Each requester offers an operand pair and opcode under a valid/ready handshake. A round-robin arbiter grants one request per cycle; the result lands in a single registered output slot with backpressure.
- Sits between the top-level pin-mux logic and the shared arithmetic datapath, and replaces direct per-port adders.

---
 rtl/alu_share_arbiter_if.sv | 28 ++
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Handshake bundle between the requesters/result consumer and the shared ALU arbiter.
// The master side drives requests and result acceptance; the slave side is the arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*2-1:0]     req_op;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic                  res_flag;
    logic [1:0]            res_id;
    logic [15:0]           op_count;

    modport master (
        output req_valid, req_a, req_b, req_op, res_ready,
        input  req_ready, res_valid, res_data, res_flag, res_id, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, res_ready,
        output req_ready, res_valid, res_data, res_flag, res_id, op_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ADD/SUB/AND/XOR ALU among four requesters.
// One grant per cycle into a single registered result slot with backpressure.
module alu_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_share_arbiter_if.slave  bus
);

    logic [1:0]       ptr_r;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic             res_flag_r;
    logic [1:0]       res_id_r;
    logic [15:0]      op_count_r;

    logic             slot_free_s;
    logic             grant_found_s;
    logic [1:0]       grant_id_s;
    logic             accept_s;
    logic [NREQ-1:0]  req_ready_s;
    logic [WIDTH-1:0] a_arr_s [NREQ];
    logic [WIDTH-1:0] b_arr_s [NREQ];
    logic [1:0]       op_arr_s [NREQ];
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [1:0]       sel_op_s;
    logic [WIDTH:0]   alu_res_s;

    // MSB of the WIDTH+1-bit result carries the ADD carry-out or the SUB borrow.
    function automatic logic [WIDTH:0] alu_f(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH:0] r;
        r = {(WIDTH+1){1'b0}};
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            2'b10:   r = {1'b0, a & b};
            2'b11:   r = {1'b0, a ^ b};
            default: r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    assign slot_free_s = ~res_valid_r | bus.res_ready;

    // Round-robin search starting at ptr_r for the first valid requester.
    always_comb begin
        logic [1:0] cand_id;
        logic       take;
        grant_found_s = 1'b0;
        grant_id_s    = 2'd0;
        cand_id       = 2'd0;
        take          = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_id       = ptr_r + 2'(k);
            take          = ~grant_found_s & bus.req_valid[cand_id];
            grant_id_s    = take ? cand_id : grant_id_s;
            grant_found_s = grant_found_s | take;
        end
    end

    // Grant is suppressed while reset is held so nothing is accepted into a clearing slot.
    assign accept_s    = slot_free_s & grant_found_s & ~rst;
    assign req_ready_s = accept_s ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id_s) : {NREQ{1'b0}};

    // Unpack the per-requester operand buses into indexable arrays.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            a_arr_s[k]  = bus.req_a[k*WIDTH +: WIDTH];
            b_arr_s[k]  = bus.req_b[k*WIDTH +: WIDTH];
            op_arr_s[k] = bus.req_op[k*2 +: 2];
        end
    end

    assign sel_a_s   = a_arr_s[grant_id_s];
    assign sel_b_s   = b_arr_s[grant_id_s];
    assign sel_op_s  = op_arr_s[grant_id_s];
    assign alu_res_s = alu_f(sel_a_s, sel_b_s, sel_op_s);

    // Result slot, rotation pointer and handshake counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= 2'd0;
            res_valid_r <= 1'b0;
            res_data_r  <= {WIDTH{1'b0}};
            res_flag_r  <= 1'b0;
            res_id_r    <= 2'd0;
            op_count_r  <= 16'd0;
        end else begin
            if (accept_s) begin
                res_data_r  <= alu_res_s[WIDTH-1:0];
                res_flag_r  <= alu_res_s[WIDTH];
                res_id_r    <= grant_id_s;
                res_valid_r <= 1'b1;
                ptr_r       <= grant_id_s + 2'd1;
            end else if (slot_free_s) begin
                res_valid_r <= 1'b0;
            end else begin
                res_valid_r <= res_valid_r;
            end
            if (res_valid_r && bus.res_ready) begin
                op_count_r <= op_count_r + 16'd1;
            end else begin
                op_count_r <= op_count_r;
            end
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.res_flag  = res_flag_r;
    assign bus.res_id    = res_id_r;
    assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with hand-computed expectations.
module tb_alu_share_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_share_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

    alu_share_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bus.req_a[p*8 +: 8] = a;
        bus.req_b[p*8 +: 8] = b;
        bus.req_op[p*2 +: 2] = op;
    endtask

    task automatic check_res(input string tag, input logic [7:0] data, input logic flag,
                             input logic [1:0] id);
        check_eq({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, bus.res_data}, {24'd0, data});
        check_eq({tag, "_flag"}, {31'd0, bus.res_flag}, {31'd0, flag});
        check_eq({tag, "_id"}, {30'd0, bus.res_id}, {30'd0, id});
    endtask

    initial begin
        logic [1:0] exp_id;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.req_op    = 8'd0;
        bus.res_ready = 1'b0;

        // Reset state
        tick();
        check_eq("rst_valid", {31'd0, bus.res_valid}, 32'd0);
        check_eq("rst_data", {24'd0, bus.res_data}, 32'd0);
        check_eq("rst_flag", {31'd0, bus.res_flag}, 32'd0);
        check_eq("rst_id", {30'd0, bus.res_id}, 32'd0);
        check_eq("rst_count", {16'd0, bus.op_count}, 32'd0);
        check_eq("rst_ready", {28'd0, bus.req_ready}, 32'd0);
        bus.req_valid = 4'b1111;
        #1;
        check_eq("rst_ready_busy", {28'd0, bus.req_ready}, 32'd0);
        bus.req_valid = 4'b0000;
        tick();
        rst = 1'b0;

        // Single ADD on port 2 with carry-out
        set_req(2, 8'hF0, 8'h20, 2'b00);
        bus.req_valid = 4'b0100;
        bus.res_ready = 1'b1;
        #1;
        check_eq("t1_ready", {28'd0, bus.req_ready}, 32'h4);
        tick();
        bus.req_valid = 4'b0000;
        check_res("t1", 8'h10, 1'b1, 2'd2);
        check_eq("t1_count0", {16'd0, bus.op_count}, 32'd0);
        tick();
        check_eq("t1_drained", {31'd0, bus.res_valid}, 32'd0);
        check_eq("t1_count1", {16'd0, bus.op_count}, 32'd1);

        // SUB / AND / XOR back to back on port 0 (pointer sits at 3)
        set_req(0, 8'h05, 8'h07, 2'b01);
        bus.req_valid = 4'b0001;
        #1;
        check_eq("sub_ready", {28'd0, bus.req_ready}, 32'h1);
        tick();
        check_res("sub", 8'hFE, 1'b1, 2'd0);
        set_req(0, 8'hCC, 8'hAA, 2'b10);
        tick();
        check_res("and", 8'h88, 1'b0, 2'd0);
        check_eq("and_count", {16'd0, bus.op_count}, 32'd2);
        set_req(0, 8'hCC, 8'hAA, 2'b11);
        tick();
        check_res("xor", 8'h66, 1'b0, 2'd0);
        check_eq("xor_count", {16'd0, bus.op_count}, 32'd3);
        bus.req_valid = 4'b0000;
        tick();
        check_eq("t2_idle", {31'd0, bus.res_valid}, 32'd0);
        check_eq("t2_count", {16'd0, bus.op_count}, 32'd4);

        // Round robin, all ports valid; pointer starts at 1
        for (int i = 0; i < 4; i++) set_req(i, 8'(i), 8'h10, 2'b00);
        bus.req_valid = 4'b1111;
        exp_id = 2'd1;
        for (int n = 0; n < 8; n++) begin
            #1;
            check_eq("rr_ready", {28'd0, bus.req_ready}, 32'd1 << exp_id);
            tick();
            check_res("rr", 8'h10 + {6'd0, exp_id}, 1'b0, exp_id);
            exp_id = exp_id + 2'd1;
        end
        check_eq("rr_count", {16'd0, bus.op_count}, 32'd11);

        // Backpressure with ports 1 and 3 valid; port 0 result held
        bus.req_valid = 4'b1010;
        bus.res_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            check_eq("bp_ready", {28'd0, bus.req_ready}, 32'd0);
            tick();
            check_res("bp_hold", 8'h10, 1'b0, 2'd0);
            check_eq("bp_count", {16'd0, bus.op_count}, 32'd11);
        end
        bus.res_ready = 1'b1;
        #1;
        check_eq("bp_rel_ready", {28'd0, bus.req_ready}, 32'h2);
        tick();
        check_res("bp_p1", 8'h11, 1'b0, 2'd1);
        check_eq("bp_p1_count", {16'd0, bus.op_count}, 32'd12);
        check_eq("bp_p3_ready", {28'd0, bus.req_ready}, 32'h8);
        tick();
        check_res("bp_p3", 8'h13, 1'b0, 2'd3);
        check_eq("bp_p3_count", {16'd0, bus.op_count}, 32'd13);
        bus.req_valid = 4'b0000;
        tick();
        check_eq("bp_count_end", {16'd0, bus.op_count}, 32'd14);

        // Asynchronous reset with a result pending
        bus.req_valid = 4'b1111;
        tick();
        check_res("mid_pre", 8'h10, 1'b0, 2'd0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_valid", {31'd0, bus.res_valid}, 32'd0);
        check_eq("mid_count", {16'd0, bus.op_count}, 32'd0);
        check_eq("mid_data", {24'd0, bus.res_data}, 32'd0);
        check_eq("mid_ready", {28'd0, bus.req_ready}, 32'd0);
        bus.req_valid = 4'b0000;
        tick();
        rst = 1'b0;

        // op_count wrap: edge k of a continuous stream has k-1 drains
        set_req(0, 8'h01, 8'h01, 2'b00);
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 65536; k++) tick();
        check_eq("wrap_ffff", {16'd0, bus.op_count}, 32'hFFFF);
        check_res("wrap_res", 8'h02, 1'b0, 2'd0);
        tick();
        check_eq("wrap_zero", {16'd0, bus.op_count}, 32'd0);
        bus.req_valid = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
